// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter and the mux it steers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_BUSY_A = 2'b01,
    S_BUSY_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Watchdog for one BUSY transaction: cleared at grant, counts while busy.
module arb_timeout_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_tc = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one shared memory port between fetch (A) and
// load/store (B), with back-to-back handover and a sticky watchdog error.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic we_b,
  input  logic mem_ready,
  output logic sel,
  output logic mem_req,
  output logic mem_we,
  output logic ack_a,
  output logic ack_b,
  output logic busy,
  output logic err
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  state_t r_state;
  logic   r_last_grant;
  logic   w_tc, w_busy_st, w_done, w_timeout, w_arb;
  logic   w_cand_a, w_cand_b, w_grant_v, w_grant_b;

  arb_timeout_cnt #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_grant_v),
    .i_en (w_busy_st),
    .o_tc (w_tc)
  );

  // Arbitration runs in IDLE and on the completing edge of a transaction,
  // where the finishing requester is masked so the other side gets the port.
  always_comb begin
    w_busy_st = (r_state != S_IDLE);
    w_done    = w_busy_st && (mem_ready || w_tc);
    w_timeout = w_busy_st && w_tc && !mem_ready;
    w_arb     = !w_busy_st || w_done;
    w_cand_a  = req_a && (r_state != S_BUSY_A);
    w_cand_b  = req_b && (r_state != S_BUSY_B);
    w_grant_v = w_arb && (w_cand_a || w_cand_b);
    w_grant_b = w_cand_b && (!w_cand_a || (r_last_grant == SEL_A));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= SEL_B;
      sel          <= SEL_A;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      ack_a <= w_done && (r_state == S_BUSY_A);
      ack_b <= w_done && (r_state == S_BUSY_B);
      if (w_timeout) begin
        err <= 1'b1;
      end
      if (w_grant_v) begin
        r_state      <= w_grant_b ? S_BUSY_B : S_BUSY_A;
        r_last_grant <= w_grant_b ? SEL_B : SEL_A;
        sel          <= w_grant_b ? SEL_B : SEL_A;
        mem_req      <= 1'b1;
        busy         <= 1'b1;
        mem_we       <= w_grant_b && we_b;
      end else if (w_arb) begin
        r_state <= S_IDLE;
        mem_req <= 1'b0;
        busy    <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared 32-bit memory port between instruction fetch (requester A) and load/store (requester B).
- Drives the select input of the 2:1 32-bit address/data mux in front of the port: sel=0 passes requester A, sel=1 passes requester B.
- Sequences each transaction as request, grant, wait for memory ready, then acknowledge.
- Provides round-robin fairness and a watchdog timeout so neither requester can starve or hang.

Parameters:
- TIMEOUT, 16, maximum BUSY cycles to wait for mem_ready before aborting; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT+1) (minimum 1), width of the watchdog counter; derived, not overridden.

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_a  in  1  fetch request, held high until ack_a
- req_b  in  1  load/store request, held high until ack_b
- we_b  in  1  write enable of requester B, sampled at grant
- mem_ready  in  1  memory completes current access this cycle
- sel  out  1  mux select: 0 = A, 1 = B
- mem_req  out  1  access active on shared port
- mem_we  out  1  write strobe to memory
- ack_a  out  1  one-cycle completion pulse to A
- ack_b  out  1  one-cycle completion pulse to B
- busy  out  1  high while in a BUSY state
- err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, sel=0, mem_req=0, mem_we=0, ack_a=ack_b=0, busy=0, err=0, counter=0, last_grant=B (so A wins the first tie).
- States are IDLE, BUSY_A and BUSY_B.
- IDLE:
  - Only one request high at an edge: go to BUSY of that requester.
  - Both requests high: grant the one that is not last_grant.
  - On grant: sel=granted, mem_req=1, busy=1, mem_we=we_b if B else 0, last_grant=granted, counter=0.
  - Latency: a request sampled at edge N gives mem_req high after edge N.
  - No request: stay in IDLE, mem_req=0, sel holds its last value.
- BUSY_x:
  - sel, mem_req and mem_we hold stable.
  - Changes on req_x, req_other or we_b are ignored until completion.
  - Counter increments each cycle.
- Completion (mem_ready=1 at an edge while in BUSY_x):
  - ack_x is 1 for exactly the next cycle; mem_req=0.
  - Re-arbitrate at that same edge with req_x masked.
  - If req_other is high, go directly to BUSY_other with the grant registers above. This is back-to-back with no bubble; mem_req stays 1 and sel flips.
  - Otherwise go to IDLE.
  - A requester re-requesting after its own ack waits at least one IDLE cycle.
- Timeout (TIMEOUT>0, counter reaches TIMEOUT-1 with mem_ready=0):
  - Treated as completion: ack_x pulses and err is set to 1 and stays set.
  - Next state follows the completion rule above.
- mem_ready in IDLE is ignored.
- mem_ready and timeout on the same edge count as a normal completion; err is not set.
- ack_a and ack_b are never high together.
- mem_req=0 whenever state is IDLE.
- rst asserted mid-transaction returns everything to reset values on that edge; no ack is issued for the aborted access.

Decomposition:
- Shared package: state encoding constants S_IDLE=2'b00, S_BUSY_A=2'b01, S_BUSY_B=2'b10; select constants SEL_A=1'b0, SEL_B=1'b1.
- The same package is reused by the top level that wires sel to the mux Control input.
- One sub-module: arb_timeout_cnt (clear, enable, terminal-count output; parameters TIMEOUT and CNT_W).
- The FSM, priority logic and output registers stay in mem_port_arbiter.

Test Plan:
- Reset, then req_a=1 at cycle 2 and mem_ready=1 at cycle 5 -> mem_req=1 and sel=0 from cycle 3; ack_a=1 only in cycle 6; back to IDLE with mem_req=0.
- req_a and req_b both high from reset release, mem_ready pulsed every 3rd cycle -> grants alternate A,B,A,B with no bubble between them; sel toggles at each completion; no ack overlap.
- req_b=1 with we_b=1 at grant, we_b dropped to 0 the next cycle -> mem_we stays 1 for the whole transaction; sel=1; ack_b pulses once.
- TIMEOUT=16, req_a held, mem_ready never asserted -> ack_a pulses 16 cycles after grant; err=1 and stays 1 through later normal transactions until rst.
- rst pulsed while in BUSY_B -> next cycle mem_req=0, sel=0, busy=0, err=0, no ack_b; a subsequent tie grants A first.
- TIMEOUT=0, mem_ready withheld for 100 cycles -> no ack and err stays 0; a completion at cycle 100 produces a single ack.
